// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem handshake, 1-entry skid buffer, IF/ID register.
// Optional FETCH_PERF_EN adds saturating stall/squash counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        pipe_continue,
  input  logic        pipe_clearStateFet,
  input  logic        branch,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc_s1,
  output logic        valid_s1
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_squash_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_SQUASH} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_s1_q, pc_s1_d;
  logic        valid_s1_q, valid_s1_d;

  logic        req_int;
  logic        resp;
  logic        accept;
  logic        discard;
  logic        direct;
  logic [31:0] target_al;

  // A request is presented whenever one is outstanding, or in REQ with room to land the word.
  assign req_int   = (state_q != S_REQ) || !skid_vld_q;
  assign imem_req  = i_reset && req_int;
  assign imem_addr = pc_q;

  assign target_al = pc_target & 32'hFFFF_FFFC;
  assign resp      = imem_rvalid && req_int;
  assign accept    = resp && (state_q != S_SQUASH) && !branch;
  assign discard   = resp && ((state_q == S_SQUASH) || branch);
  assign direct    = pipe_continue && !pipe_clearStateFet;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    if (branch) begin
      // The old address must stay on the bus until its response drains.
      if (req_int && !imem_rvalid) begin
        state_d = S_SQUASH;
        redir_d = target_al;
      end else begin
        state_d = S_REQ;
        pc_d    = target_al;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_int) begin
            if (imem_rvalid) pc_d = pc_q + 32'd4;
            else             state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
        S_SQUASH: begin
          if (imem_rvalid) begin
            pc_d    = redir_q;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    if (branch) begin
      skid_vld_d = 1'b0;
    end else if (accept && !direct) begin
      skid_vld_d  = 1'b1;
      skid_inst_d = imem_rdata;
      skid_pc_d   = pc_q;
    end else if (skid_vld_q && direct) begin
      skid_vld_d = 1'b0;
    end
  end

  always_comb begin
    inst_d     = inst_q;
    pc_s1_d    = pc_s1_q;
    valid_s1_d = valid_s1_q;
    if (branch || pipe_clearStateFet) begin
      inst_d     = NOP_INST;
      valid_s1_d = 1'b0;
    end else if (!pipe_continue) begin
      inst_d     = inst_q;
    end else if (skid_vld_q) begin
      inst_d     = skid_inst_q;
      pc_s1_d    = skid_pc_q;
      valid_s1_d = 1'b1;
    end else if (accept) begin
      inst_d     = imem_rdata;
      pc_s1_d    = pc_q;
      valid_s1_d = 1'b1;
    end else begin
      inst_d     = NOP_INST;
      valid_s1_d = 1'b0;
    end
  end

  // IF/ID boundary and fetch control
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      skid_vld_q <= 1'b0;
      inst_q     <= NOP_INST;
      pc_s1_q    <= RESET_PC;
      valid_s1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      skid_vld_q <= skid_vld_d;
      inst_q     <= inst_d;
      pc_s1_q    <= pc_s1_d;
      valid_s1_q <= valid_s1_d;
    end
  end

  always_ff @(posedge i_clk) begin
    redir_q     <= redir_d;
    skid_inst_q <= skid_inst_d;
    skid_pc_q   <= skid_pc_d;
  end

  assign inst     = inst_q;
  assign pc_s1    = pc_s1_q;
  assign valid_s1 = valid_s1_q;

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;

  // A discarded response and a flushed skid entry never coincide: the skid is empty whenever a request is out.
  always_comb begin
    stall_cnt_d  = sat_inc(stall_cnt_q, !pipe_continue);
    squash_cnt_d = sat_inc(squash_cnt_q, discard || (branch && skid_vld_q));
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_q  <= 32'd0;
      squash_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_squash_cnt = squash_cnt_q;
`endif

endmodule
